// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: size codes, FSM states,
// byte-enable generation and the request legality check.
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, CAPT, RESP} state_t;

  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: be_gen = 4'b0001 << lane;
      SZ_HALF: be_gen = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be_gen = 4'b1111;
      default: be_gen = 4'b0000;
    endcase
  endfunction

  // Illegal size or a lane offset that does not fit the access width.
  function automatic logic bad_req(input logic [1:0] size, input logic [1:0] lane);
    bad_req = (size == 2'b11) ||
              (size == SZ_HALF && lane[0]) ||
              (size == SZ_WORD && lane != 2'b00);
  endfunction

endpackage

// File: rtl/mau_load_align.sv
// Selects the addressed byte/half from a memory word and sign/zero-extends it.
module mau_load_align
  import mau_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  lane,
  input  logic [31:0] word_in,
  output logic [31:0] data_out
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word_in[{lane, 3'b000} +: 8];
    h = lane[1] ? word_in[31:16] : word_in[15:0];
    case (size)
      SZ_BYTE: data_out = {{24{sign_ext & b[7]}}, b};
      SZ_HALF: data_out = {{16{sign_ext & h[15]}}, h};
      default: data_out = word_in;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Bus initiator: turns one CPU load/store into a single CS/RW/BE memory
// transaction and reports completion with a one-cycle done pulse.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic        CS,
  output logic        RW,
  output logic [3:0]  BE,
  output logic [29:0] Addr,
  output logic [31:0] DataOut,
  input  logic [31:0] DataIn,
  input  logic        DataReady
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state, state_n;
  logic [CW-1:0] wcnt, wcnt_n;
  logic          st_q, st_n, sx_q, sx_n, errp_q, errp_n;
  logic [1:0]    sz_q, sz_n, lane_q, lane_n;
  logic          cs_n, rw_n, done_n, err_n, busy_n;
  logic [3:0]    be_n;
  logic [29:0]   addr_n;
  logic [31:0]   dout_n, rdata_n, ld_data;

  mau_load_align u_align (
    .size     (sz_q),
    .sign_ext (sx_q),
    .lane     (lane_q),
    .word_in  (DataIn),
    .data_out (ld_data)
  );

  always_comb begin
    state_n = state;  wcnt_n = wcnt;
    st_n    = st_q;   sx_n   = sx_q;   sz_n = sz_q;  lane_n = lane_q;
    errp_n  = errp_q;
    cs_n    = CS;     rw_n   = RW;     be_n = BE;    addr_n = Addr;
    dout_n  = DataOut; rdata_n = rdata; busy_n = busy;
    done_n  = 1'b0;   err_n  = 1'b0;
    case (state)
      IDLE: if (req) begin
        st_n   = is_store;
        sz_n   = size;
        sx_n   = sign_ext;
        lane_n = addr[1:0];
        busy_n = 1'b1;
        if (bad_req(size, addr[1:0])) begin
          errp_n  = 1'b1;
          state_n = RESP;
        end else begin
          errp_n  = 1'b0;
          cs_n    = 1'b1;
          rw_n    = is_store;
          be_n    = be_gen(size, addr[1:0]);
          addr_n  = addr[31:2];
          case (size)
            SZ_BYTE: dout_n = {4{wdata[7:0]}};
            SZ_HALF: dout_n = {2{wdata[15:0]}};
            default: dout_n = wdata;
          endcase
          wcnt_n  = '0;
          state_n = REQ;
        end
      end
      REQ: if (DataReady) begin
        cs_n    = 1'b0;
        state_n = st_q ? RESP : CAPT;
      end else begin
        wcnt_n = wcnt + 1'b1;
        // Abort on the edge where the wait count reaches TIMEOUT.
        if (wcnt == CW'(TIMEOUT - 1)) begin
          cs_n    = 1'b0;
          errp_n  = 1'b1;
          state_n = RESP;
        end
      end
      CAPT: begin
        rdata_n = ld_data;
        state_n = RESP;
      end
      RESP: begin
        done_n  = 1'b1;
        err_n   = errp_q;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;  wcnt <= '0;
      st_q  <= 1'b0;  sx_q <= 1'b0;  sz_q <= '0;  lane_q <= '0;  errp_q <= 1'b0;
      CS    <= 1'b0;  RW   <= 1'b0;  BE   <= '0;  Addr   <= '0;  DataOut <= '0;
      rdata <= '0;    done <= 1'b0;  err  <= 1'b0; busy  <= 1'b0;
    end else begin
      state <= state_n; wcnt <= wcnt_n;
      st_q  <= st_n;    sx_q <= sx_n;  sz_q <= sz_n; lane_q <= lane_n; errp_q <= errp_n;
      CS    <= cs_n;    RW   <= rw_n;  BE   <= be_n; Addr   <= addr_n; DataOut <= dout_n;
      rdata <= rdata_n; done <= done_n; err <= err_n; busy  <= busy_n;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit against a word-array
// memory and a byte-level reference model.
module tb_mem_access_unit;

  logic        Clk = 1'b0;
  logic        Reset, req, is_store, sign_ext, done, err, busy, CS, RW, DataReady;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata, DataOut, DataIn;
  logic [3:0]  BE;
  logic [29:0] Addr;

  int passed = 0;
  int total  = 0;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  logic [31:0] exp_rd;
  int          dr_mode;
  int          stall = 0;

  mem_access_unit #(.TIMEOUT(16)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .is_store(is_store), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .rdata(rdata), .done(done),
    .err(err), .busy(busy), .CS(CS), .RW(RW), .BE(BE), .Addr(Addr),
    .DataOut(DataOut), .DataIn(DataIn), .DataReady(DataReady)
  );

  always #5 Clk = ~Clk;

  // Memory: transfer at a rising edge with CS and DataReady both high.
  always @(posedge Clk) begin
    if (CS && DataReady) begin
      if (RW) begin
        for (int i = 0; i < 4; i++)
          if (BE[i]) mem[Addr[5:0]][8*i +: 8] <= DataOut[8*i +: 8];
      end else begin
        DataIn <= mem[Addr[5:0]];
      end
    end
  end

  // Ready: 0 = held low, 1 = tied high, 2 = random with bounded stalls.
  always @(negedge Clk) begin
    if (dr_mode == 1)      DataReady = 1'b1;
    else if (dr_mode == 0) DataReady = 1'b0;
    else begin
      if (CS && stall >= 3) DataReady = 1'b1;
      else                  DataReady = 1'($urandom_range(0, 1));
      stall = (CS && !DataReady) ? stall + 1 : 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // One request issued at a falling edge; returns after the done pulse.
  task automatic do_req(input string tag, input logic st, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, input int exp_lat);
    logic        bad;
    logic [31:0] w, ev, eo;
    logic [3:0]  eb;
    int          lat, sh;
    bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    req = 1'b1; is_store = st; size = sz; sign_ext = sx; addr = a; wdata = wd;
    @(negedge Clk);
    req = 1'b0; addr = $urandom; wdata = $urandom;
    if (bad) begin
      chk({tag, ".cs_err"}, 32'(CS), 32'd0);
    end else begin
      sh = 8 * int'(a[1:0]);
      eb = (sz == 2'd0) ? 4'(1 << a[1:0]) : (sz == 2'd1) ? 4'(3 << a[1:0]) : 4'hF;
      eo = (sz == 2'd0) ? wd[7:0] * 32'h0101_0101 : (sz == 2'd1) ? wd[15:0] * 32'h0001_0001 : wd;
      chk({tag, ".cs"},   32'(CS),   32'd1);
      chk({tag, ".rw"},   32'(RW),   32'(st));
      chk({tag, ".addr"}, 32'(Addr), 32'(a >> 2));
      chk({tag, ".be"},   32'(BE),   32'(eb));
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      if (st) chk({tag, ".dout"}, DataOut, eo);
    end
    lat = 1;
    while (!done && lat < 40) begin @(negedge Clk); lat++; end
    chk({tag, ".done"}, 32'(done), 32'd1);
    if (exp_lat > 0) chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".err"}, 32'(err), 32'(bad));
    if (!bad && st) begin
      w = ref_mem[a[7:2]];
      if (sz == 2'd0)      w[sh +: 8]  = wd[7:0];
      else if (sz == 2'd1) w[sh +: 16] = wd[15:0];
      else                 w = wd;
      ref_mem[a[7:2]] = w;
    end else if (!bad) begin
      w = ref_mem[a[7:2]] >> (8 * int'(a[1:0]));
      if (sz == 2'd0)      ev = (sx && w[7])  ? (w & 32'hFF)   - 32'h100   : (w & 32'hFF);
      else if (sz == 2'd1) ev = (sx && w[15]) ? (w & 32'hFFFF) - 32'h10000 : (w & 32'hFFFF);
      else                 ev = w;
      exp_rd = ev;
    end
    chk({tag, ".rdata"}, rdata, exp_rd);
    @(negedge Clk);
    chk({tag, ".pulse"}, 32'(done), 32'd0);
    chk({tag, ".idle"},  32'(busy), 32'd0);
  endtask

  initial begin
    int cyc, dcnt;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    exp_rd = '0; dr_mode = 1;
    Reset = 1'b1; req = 1'b0; is_store = 1'b0; size = 2'd0; sign_ext = 1'b0;
    addr = '0; wdata = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    chk("rst.cs", 32'(CS), 32'd0);       chk("rst.rw", 32'(RW), 32'd0);
    chk("rst.be", 32'(BE), 32'd0);       chk("rst.addr", 32'(Addr), 32'd0);
    chk("rst.dout", DataOut, 32'd0);     chk("rst.rdata", rdata, 32'd0);
    chk("rst.done", 32'(done), 32'd0);   chk("rst.err", 32'(err), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);

    do_req("st_word", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 3);
    do_req("st_w2",   1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF0000, 3);
    do_req("ld_bs",   1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 4);
    chk("ld_bs.lit", rdata, 32'hFFFFFF80);
    do_req("ld_bz",   1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 4);
    chk("ld_bz.lit", rdata, 32'h00000080);
    do_req("st_w3",   1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF1234, 3);
    do_req("ld_hs",   1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 4);
    chk("ld_hs.lit", rdata, 32'hFFFF80FF);
    do_req("st_half", 1'b1, 2'd1, 1'b0, 32'h02, 32'h0000ABCD, 3);
    do_req("ld_half", 1'b0, 2'd1, 1'b0, 32'h02, 32'h0, 4);
    do_req("ld_mis",  1'b0, 2'd2, 1'b0, 32'h01, 32'h0, 2);
    do_req("ill_sz",  1'b1, 2'd3, 1'b0, 32'h04, 32'h1, 2);

    // Timeout: CS held for TIMEOUT cycles, then done with err, rdata kept.
    dr_mode = 0;
    req = 1'b1; is_store = 1'b0; size = 2'd2; addr = 32'h20;
    @(negedge Clk); req = 1'b0;
    cyc = 0;
    while (CS && cyc < 40) begin @(negedge Clk); cyc++; end
    chk("to.cs_cycles", 32'(cyc), 32'd16);
    cyc = 0;
    while (!done && cyc < 5) begin @(negedge Clk); cyc++; end
    chk("to.done", 32'(done), 32'd1);
    chk("to.err", 32'(err), 32'd1);
    chk("to.rdata", rdata, exp_rd);
    @(negedge Clk);

    // Reset in the middle of a stalled store: aborted silently.
    req = 1'b1; is_store = 1'b1; size = 2'd2; addr = 32'h24; wdata = 32'h12345678;
    @(negedge Clk); req = 1'b0;
    repeat (3) @(negedge Clk);
    chk("ab.cs_before", 32'(CS), 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("ab.cs", 32'(CS), 32'd0);
    chk("ab.busy", 32'(busy), 32'd0);
    exp_rd = '0;
    dcnt = 0;
    repeat (20) begin @(negedge Clk); if (done) dcnt++; end
    chk("ab.no_done", 32'(dcnt), 32'd0);
    dr_mode = 1;
    @(negedge Clk);
    do_req("post_st", 1'b1, 2'd2, 1'b0, 32'h24, 32'hCAFEF00D, 3);
    do_req("post_ld", 1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 4);

    // Random mix with bounded random ready stalls.
    dr_mode = 2;
    for (int n = 0; n < 60; n++) begin
      do_req("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
